// File: rtl/scene_sphere_reader.sv
// rtl/scene_sphere_reader.sv - sphere register file read walker with 2-entry prefetch FIFO
//
// Purpose:
//   On each accepted frame_start, walks sphere slots 0..NUM_SPHERES-1 in order,
//   reads position and colour through a 1-cycle-latency read port and streams
//   each record over a valid/ready handshake to the ray-intersection stage.
//   A 2-entry FIFO plus a credit check that counts the current pop lets reads
//   be issued back to back, so one record per cycle is sustained while the
//   consumer stays ready.
//
// Optional feature:
//   SPHERE_SKIP_BLACK_EN - when defined, records whose colour is 24'h000000
//   (unused slot) are dropped at FIFO write. The read credit is released and
//   done still pulses even if every slot of the frame was dropped.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   frame_start  in   1-cycle pulse, begin walking the scene
//   busy         out  high from accepted frame_start through the done pulse
//   done         out  1-cycle pulse once every slot is emitted or dropped
//   mem_rd_en    out  read strobe to sphere storage
//   mem_addr     out  slot address, valid with mem_rd_en
//   mem_pos      in   {z,y,x} 16.16, valid the cycle after mem_rd_en
//   mem_col      in   {b,g,r}, valid the cycle after mem_rd_en
//   sph_valid    out  output record valid
//   sph_ready    in   consumer ready
//   sph_pos      out  record position
//   sph_col      out  record colour
//   sph_idx      out  record slot index

module scene_sphere_reader #(
  parameter int NUM_SPHERES = 8,
  parameter int ADDR_W      = 3
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              frame_start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [95:0]       mem_pos,
  input  logic [23:0]       mem_col,
  output logic              sph_valid,
  input  logic              sph_ready,
  output logic [95:0]       sph_pos,
  output logic [23:0]       sph_col,
  output logic [ADDR_W-1:0] sph_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_SPHERES - 1);

  state_t            state;
  logic [ADDR_W-1:0] slot;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_idx;

  logic [95:0]       fifo_pos [2];
  logic [23:0]       fifo_col [2];
  logic [ADDR_W-1:0] fifo_idx [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic       pop;
  logic       push;
  logic       keep;
  logic [1:0] occ_after_pop;
  logic       issue;
  logic       accept;
  logic       drain_done;

  assign pop = (count != 2'd0) && sph_ready;

`ifdef SPHERE_SKIP_BLACK_EN
  assign keep = (mem_col != 24'h000000);
`else
  assign keep = 1'b1;
`endif

  assign push = inflight && keep;

  // Occupancy the FIFO will hold once the current pop retires and the
  // in-flight read lands; a new read is safe while that stays below 2.
  assign occ_after_pop = count + {1'b0, inflight} - {1'b0, pop};
  assign issue         = (state == S_RUN) && (occ_after_pop < 2'd2);

  // The done cycle is already IDLE, so !done blocks a restart in that cycle.
  assign accept     = (state == S_IDLE) && frame_start && !done;
  assign drain_done = (state == S_DRAIN) && !inflight &&
                      ((count - {1'b0, pop}) == 2'd0);

  assign mem_rd_en = issue;
  assign mem_addr  = slot;
  assign sph_valid = (count != 2'd0);
  assign sph_pos   = fifo_pos[rd_ptr];
  assign sph_col   = fifo_col[rd_ptr];
  assign sph_idx   = fifo_idx[rd_ptr];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      slot         <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pos[i] <= '0;
        fifo_col[i] <= '0;
        fifo_idx[i] <= '0;
      end
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_idx <= slot;
      end

      case (state)
        S_IDLE: begin
          if (done) begin
            busy <= 1'b0;
          end
          if (accept) begin
            state <= S_RUN;
            slot  <= '0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (issue) begin
            // Counter parks on the last slot; no wrap within a frame.
            if (slot == LAST_SLOT) begin
              state <= S_DRAIN;
            end else begin
              slot <= slot + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) begin
        fifo_pos[wr_ptr] <= mem_pos;
        fifo_col[wr_ptr] <= mem_col;
        fifo_idx[wr_ptr] <= inflight_idx;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_scene_sphere_reader.sv
// tb/tb_scene_sphere_reader.sv - randomized self-checking bench for scene_sphere_reader

module tb_scene_sphere_reader;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          CLOCK_50;
  logic          RESET_N;
  logic          frame_start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [95:0]   mem_pos;
  logic [23:0]   mem_col;
  logic          sph_valid;
  logic          sph_ready;
  logic [95:0]   sph_pos;
  logic [23:0]   sph_col;
  logic [AW-1:0] sph_idx;

  scene_sphere_reader #(.NUM_SPHERES(N), .ADDR_W(AW)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_pos     (mem_pos),
    .mem_col     (mem_col),
    .sph_valid   (sph_valid),
    .sph_ready   (sph_ready),
    .sph_pos     (sph_pos),
    .sph_col     (sph_col),
    .sph_idx     (sph_idx)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Sphere storage model: 1-cycle read latency.
  logic [95:0]   pos_mem [N];
  logic [23:0]   col_mem [N];
  logic          rd_q;
  logic [AW-1:0] addr_q;

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      rd_q   <= mem_rd_en;
      addr_q <= mem_addr;
    end
  end

  assign mem_pos = rd_q ? pos_mem[addr_q] : 96'hdead_beef_dead_beef_dead_beef;
  assign mem_col = rd_q ? col_mem[addr_q] : 24'h5a5a5a;

  // Consumer: 0 random, 1 always ready, 2 never ready.
  int rdy_mode = 1;
  always @(posedge CLOCK_50) begin
    #1;
    if (rdy_mode == 1) sph_ready = 1'b1;
    else if (rdy_mode == 2) sph_ready = 1'b0;
    else sph_ready = ($urandom_range(3) != 0);
  end

  // Reference model state.
  int          exp_q[$];
  bit          model_busy = 0;
  int          rd_next = 0;
  int          rd_cnt = 0;
  int          rec_cnt = 0;
  int          done_cnt = 0;
  int          first_rd_cyc = -1;
  int          first_valid_cyc = -1;
  int          last_rec_cyc = -1;
  int          done_cyc = -1;
  logic [95:0] rec2_pos;
  logic [23:0] rec2_col;
  bit          stall_prev = 0;
  bit          done_prev = 0;
  logic [95:0] p_prev;
  logic [23:0] c_prev;
  logic [AW-1:0] i_prev;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit slot_emitted(input int s);
`ifdef SPHERE_SKIP_BLACK_EN
    return col_mem[s] != 24'h0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int s = 0; s < N; s++) if (slot_emitted(s)) n++;
    return n;
  endfunction

  // Single compare process: all outputs checked against the model every cycle.
  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      stall_prev = 0;
      done_prev  = 0;
    end else begin
      check("busy", busy, model_busy);
      if (mem_rd_en) begin
        check("rd_addr_order", mem_addr, rd_next);
        check("rd_in_frame", model_busy, 1);
        rd_next++;
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (stall_prev) begin
        check("stall_valid", sph_valid, 1);
        check("stall_pos", sph_pos, p_prev);
        check("stall_col", sph_col, c_prev);
        check("stall_idx", sph_idx, i_prev);
      end
      if (sph_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (sph_valid && sph_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", sph_idx, 'hff);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("rec_idx", sph_idx, e);
          check("rec_pos", sph_pos, pos_mem[e]);
          check("rec_col", sph_col, col_mem[e]);
        end
        if (sph_idx == 2) begin
          rec2_pos = sph_pos;
          rec2_col = sph_col;
        end
        rec_cnt++;
        last_rec_cyc = cyc;
      end
      stall_prev = sph_valid && !sph_ready;
      p_prev = sph_pos;
      c_prev = sph_col;
      i_prev = sph_idx;
      if (done) begin
        check("done_single_cycle", done_prev, 0);
        check("done_all_emitted", exp_q.size(), 0);
        done_cnt++;
        done_cyc = cyc;
        model_busy = 0;
      end
      done_prev = done;
    end
  end

  task automatic fill(input int zero_pct);
    for (int s = 0; s < N; s++) begin
      pos_mem[s] = {$urandom, $urandom, $urandom};
      col_mem[s] = ($urandom_range(99) < zero_pct) ? 24'h0 : (24'($urandom) | 24'h1);
    end
  endtask

  task automatic start_frame(output int t);
    @(posedge CLOCK_50); #1;
    frame_start = 1'b1;
    t = cyc;
    @(posedge CLOCK_50); #1;
    frame_start = 1'b0;
    model_busy = 1;
    rd_next = 0;
    rd_cnt = 0;
    rec_cnt = 0;
    first_rd_cyc = -1;
    first_valid_cyc = -1;
    last_rec_cyc = -1;
    exp_q.delete();
    for (int s = 0; s < N; s++) if (slot_emitted(s)) exp_q.push_back(s);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge CLOCK_50);
    check("done_timeout", done_cnt > d0, 1);
    #1;
  endtask

  int t;
  int d_before;

  initial begin
    RESET_N = 1'b0;
    frame_start = 1'b0;
    sph_ready = 1'b1;
    fill(0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_en", mem_rd_en, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_valid", sph_valid, 0);
    check("reset_sph_data", {sph_pos, sph_col, sph_idx}, 0);
    RESET_N = 1'b1;

    // Nominal frame, exact latency, and slot 2 bit pass-through.
    fill(0);
    pos_mem[2] = {32'h0, 32'h0001_0000, 32'h0};
    col_mem[2] = 24'hffffff;
    rdy_mode = 1;
    start_frame(t);
    wait_done(40);
    check("first_rd_latency", first_rd_cyc, t + 1);
    check("first_valid_latency", first_valid_cyc, t + 3);
    check("last_record_cycle", last_rec_cyc, t + 10);
    check("done_cycle", done_cyc, t + 11);
    check("record_count", rec_cnt, 8);
    check("slot2_pos_literal", rec2_pos, 96'h00000000_00010000_00000000);
    check("slot2_col_literal", rec2_col, 24'hffffff);
    check("idle_after_done", busy, 0);

    // frame_start while busy is ignored.
    fill(0);
    d_before = done_cnt;
    start_frame(t);
    repeat (4) @(posedge CLOCK_50);
    #1;
    frame_start = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_start = 1'b0;
    wait_done(40);
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("rebusy_records", rec_cnt, 8);
    check("rebusy_one_done", done_cnt - d_before, 1);
    check("rebusy_idle", busy, 0);

    // Consumer stall: only two reads issued while the head is held.
    fill(0);
    rdy_mode = 2;
    start_frame(t);
    for (int i = 0; i < 30 && first_valid_cyc < 0; i++) @(posedge CLOCK_50);
    check("stall_first_valid_seen", first_valid_cyc >= 0, 1);
    repeat (10) @(posedge CLOCK_50);
    #1;
    check("stall_reads", rd_cnt, 2);
    check("stall_head_idx", sph_idx, 0);
    check("stall_head_valid", sph_valid, 1);
    rdy_mode = 1;
    wait_done(60);
    check("stall_records", rec_cnt, 8);

    // Reset mid-walk at slot 3, then a clean restart from slot 0.
    fill(0);
    rdy_mode = 1;
    start_frame(t);
    begin
      bit hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
        @(negedge CLOCK_50);
        if (mem_rd_en && mem_addr == 3) hit = 1;
      end
      check("reach_slot3", hit, 1);
    end
    #1;
    RESET_N = 1'b0;
    #1;
    exp_q.delete();
    model_busy = 0;
    check("midreset_busy", busy, 0);
    check("midreset_rd_en", mem_rd_en, 0);
    check("midreset_valid", sph_valid, 0);
    check("midreset_outs", {done, mem_addr, sph_pos, sph_col, sph_idx}, 0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    rdy_mode = 0;
    start_frame(t);
    wait_done(200);
    check("restart_records", rec_cnt, 8);

    // Specific black-slot scene and an all-black scene.
    fill(0);
    col_mem[1] = 24'h0;
    col_mem[4] = 24'h0;
    rdy_mode = 1;
    start_frame(t);
    wait_done(40);
`ifdef SPHERE_SKIP_BLACK_EN
    check("black_slots_records", rec_cnt, 6);
`else
    check("black_slots_records", rec_cnt, 8);
`endif
    for (int s = 0; s < N; s++) col_mem[s] = 24'h0;
    d_before = done_cnt;
    start_frame(t);
    wait_done(40);
    repeat (5) @(posedge CLOCK_50);
    #1;
    check("all_black_done_once", done_cnt - d_before, 1);
`ifdef SPHERE_SKIP_BLACK_EN
    check("all_black_records", rec_cnt, 0);
    check("all_black_no_valid", first_valid_cyc, -1);
`else
    check("all_black_records", rec_cnt, 8);
`endif

    // Randomized frames: random data, random black slots, random backpressure.
    for (int f = 0; f < 8; f++) begin
      int n_exp;
      fill(25);
      n_exp = exp_count();
      rdy_mode = 0;
      start_frame(t);
      wait_done(300);
      check("rand_records", rec_cnt, n_exp);
      check("rand_reads", rd_cnt, N);
    end

    repeat (3) @(posedge CLOCK_50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
